bact_pack: RTL and testbench

BACT_PACK -- requirements
Module: bact_pack

---
 rtl/bconv_pkg.sv | 15 +
 rtl/bact_pack_shift.sv | 77 +++++++
 rtl/bact_pack.sv | 138 +++++++++++++
 tb/tb_bact_pack.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bconv_pkg.sv
// bconv_pkg: constants shared by the binary/ternary activation packer.
//   WIDTH_D   : width of one activation code
//   CODE_*    : code values (zero, positive, negative)
//   BACT_LAT  : cycles from an input beat/sync to the matching output
package bconv_pkg;

  localparam int unsigned WIDTH_D = 2;

  localparam logic [WIDTH_D-1:0] CODE_ZERO = 2'b00;
  localparam logic [WIDTH_D-1:0] CODE_POS  = 2'b01;
  localparam logic [WIDTH_D-1:0] CODE_NEG  = 2'b11;

  localparam int unsigned BACT_LAT = 3;

endpackage

// File: rtl/bact_pack_shift.sv
// bact_pack_shift: packs PACK codes of WIDTH_D bits into one output word,
// oldest code in the LSBs. A flush request with a partial word pending
// emits that word padded with CODE_ZERO and sets the sticky error flag.
// Ports:
//   i_sclk, i_rst : clock, synchronous active-high reset
//   i_clr         : clears the sticky error (frame start)
//   i_valid,i_code: incoming code and qualifier
//   i_flush       : channel/row boundary aligned with i_code
//   o_valid       : one-cycle word strobe
//   o_tdata       : packed word, held between strobes
//   o_err         : sticky framing error
module bact_pack_shift #(
  parameter int unsigned WIDTH_D = 2,
  parameter int unsigned PACK    = 4
) (
  input  logic                    i_sclk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic [WIDTH_D-1:0]      i_code,
  input  logic                    i_flush,
  output logic                    o_valid,
  output logic [WIDTH_D*PACK-1:0] o_tdata,
  output logic                    o_err
);
  import bconv_pkg::*;

  localparam int unsigned WW = WIDTH_D * PACK;
  localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [WIDTH_D-1:0] PAD = WIDTH_D'(CODE_ZERO);

  logic [WW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [WW-1:0] shifted;

  // New codes enter at the top so the first code ends up in the LSBs.
  always_comb begin
    shifted = {i_code, sh[WW-1:WIDTH_D]};
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      sh      <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_tdata <= '0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clr) o_err <= 1'b0;
      if (i_flush && (cnt != '0)) begin
        // Partial codes sit in the top cnt slots; shifting down pads zeros.
        o_tdata <= sh >> (WIDTH_D * (PACK - int'(cnt)));
        o_valid <= 1'b1;
        o_err   <= 1'b1;
        if (i_valid) begin
          sh  <= {i_code, {(PACK-1){PAD}}};
          cnt <= CW'(1);
        end else begin
          sh  <= '0;
          cnt <= '0;
        end
      end else if (i_valid) begin
        if (cnt == CW'(PACK - 1)) begin
          o_tdata <= shifted;
          o_valid <= 1'b1;
          sh      <= '0;
          cnt     <= '0;
        end else begin
          sh  <= shifted;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bact_pack.sv
// bact_pack: thresholds signed activations per channel into 2-bit codes and
// packs PACK codes per output word. Syncs are delayed to stay aligned.
// Ports:
//   i_sclk, i_rst          : clock, synchronous active-high reset
//   i_vsync/i_hsync/i_reuse: frame, row, channel start pulses
//   i_valid, i_tdata       : signed activation beat
//   i_thr_vld, i_thr       : threshold table write
//   o_vsync/o_hsync/o_reuse: syncs delayed BACT_LAT cycles
//   o_valid, o_tdata       : packed word strobe and data
//   o_err                  : sticky framing error (partial word flushed)
// Build option: define BACT_TERNARY_EN for ternary codes (01 / 11 / 00).
module bact_pack #(
  parameter int          WIDTH_I = 27,
  parameter int unsigned WIDTH_D = 2,
  parameter int unsigned PACK    = 4,
  parameter int unsigned CHANNEL = 64,
  parameter int unsigned SIZE    = 56
) (
  input  logic                      i_sclk,
  input  logic                      i_rst,
  input  logic                      i_vsync,
  input  logic                      i_hsync,
  input  logic                      i_reuse,
  input  logic                      i_valid,
  input  logic [WIDTH_I-1:0]        i_tdata,
  input  logic                      i_thr_vld,
  input  logic [WIDTH_I-1:0]        i_thr,
  output logic                      o_vsync,
  output logic                      o_hsync,
  output logic                      o_reuse,
  output logic                      o_valid,
  output logic [WIDTH_D*PACK-1:0]   o_tdata,
  output logic                      o_err
);
  import bconv_pkg::*;

  localparam int unsigned CHW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  if ((SIZE % PACK) != 0) begin : g_size_check
    $error("bact_pack: SIZE must be a multiple of PACK");
  end

  logic [WIDTH_I-1:0] thr [CHANNEL];
  logic [CHW-1:0]     wr_ptr;
  logic [CHW-1:0]     wr_addr;
  logic [CHW-1:0]     ch;

  logic signed [WIDTH_I-1:0] s1_data;
  logic signed [WIDTH_I-1:0] s1_thr;
  logic                      s1_valid;
  logic [WIDTH_D-1:0]        s2_code;
  logic                      s2_valid;
  logic [WIDTH_D-1:0]        code;

  logic [BACT_LAT-1:0] hs_d;
  logic [BACT_LAT-1:0] ru_d;
  logic [BACT_LAT-1:0] vs_d;

  // A write coinciding with frame start lands in entry 0.
  assign wr_addr = i_vsync ? '0 : wr_ptr;

  always_ff @(posedge i_sclk) begin
    if (i_thr_vld && !i_rst) thr[wr_addr] <= i_thr;
  end

  always_comb begin
    logic signed [WIDTH_I:0] data_x;
    logic signed [WIDTH_I:0] thr_x;
    data_x = {s1_data[WIDTH_I-1], s1_data};
    thr_x  = {s1_thr[WIDTH_I-1], s1_thr};
    code   = WIDTH_D'(CODE_ZERO);
    if (data_x >= thr_x) begin
      code = WIDTH_D'(CODE_POS);
    end
`ifdef BACT_TERNARY_EN
    else if (data_x <= -thr_x) begin
      code = WIDTH_D'(CODE_NEG);
    end
`endif
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      ch       <= '0;
      s1_data  <= '0;
      s1_thr   <= '0;
      s1_valid <= 1'b0;
      s2_code  <= '0;
      s2_valid <= 1'b0;
      hs_d     <= '0;
      ru_d     <= '0;
      vs_d     <= '0;
    end else begin
      if (i_vsync)
        wr_ptr <= '0;
      else if (i_thr_vld)
        wr_ptr <= (wr_ptr == CHW'(CHANNEL - 1)) ? '0 : wr_ptr + 1'b1;

      if (i_hsync)
        ch <= '0;
      else if (i_reuse && (ch != CHW'(CHANNEL - 1)))
        ch <= ch + 1'b1;

      s1_data  <= i_tdata;
      s1_thr   <= thr[ch];
      s1_valid <= i_valid;
      s2_code  <= code;
      s2_valid <= s1_valid;

      hs_d <= {hs_d[BACT_LAT-2:0], i_hsync};
      ru_d <= {ru_d[BACT_LAT-2:0], i_reuse};
      vs_d <= {vs_d[BACT_LAT-2:0], i_vsync};
    end
  end

  assign o_hsync = hs_d[BACT_LAT-1];
  assign o_reuse = ru_d[BACT_LAT-1];
  assign o_vsync = vs_d[BACT_LAT-1];

  // Boundary taps at the stage-2 position so a flush precedes the first
  // code of the new channel.
  bact_pack_shift #(
    .WIDTH_D (WIDTH_D),
    .PACK    (PACK)
  ) u_shift (
    .i_sclk  (i_sclk),
    .i_rst   (i_rst),
    .i_clr   (i_vsync),
    .i_valid (s2_valid),
    .i_code  (s2_code),
    .i_flush (hs_d[BACT_LAT-2] | ru_d[BACT_LAT-2]),
    .o_valid (o_valid),
    .o_tdata (o_tdata),
    .o_err   (o_err)
  );

endmodule

// File: tb/tb_bact_pack.sv
// tb_bact_pack: scoreboard bench for bact_pack (default parameters).
module tb_bact_pack;
  localparam int WI = 27;
  localparam int PK = 4;
  localparam int CH = 64;
  localparam int SZ = 56;

  logic          i_sclk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_vsync = 1'b0, i_hsync = 1'b0, i_reuse = 1'b0;
  logic          i_valid = 1'b0;
  logic [WI-1:0] i_tdata = '0;
  logic          i_thr_vld = 1'b0;
  logic [WI-1:0] i_thr = '0;
  logic          o_vsync, o_hsync, o_reuse, o_valid, o_err;
  logic [7:0]    o_tdata;

  always #5 i_sclk = ~i_sclk;

  bact_pack dut (
    .i_sclk(i_sclk), .i_rst(i_rst), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_reuse(i_reuse), .i_valid(i_valid), .i_tdata(i_tdata),
    .i_thr_vld(i_thr_vld), .i_thr(i_thr), .o_vsync(o_vsync),
    .o_hsync(o_hsync), .o_reuse(o_reuse), .o_valid(o_valid),
    .o_tdata(o_tdata), .o_err(o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;

  logic [7:0] sb [$];
  int         m_thr [CH];
  int         m_wr = 0, m_ch = 0, m_cnt = 0;
  logic [7:0] m_word = '0;
  logic       m_err = 1'b0;

  always @(negedge i_sclk) begin
    if (o_valid === 1'b1) begin
      logic [7:0] exp;
      n_valid++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: o_tdata=%b, no word expected", o_tdata);
      end else begin
        exp = sb.pop_front();
        if (o_tdata !== exp)
          $display("FAIL sb_word: o_tdata=%b expected %b", o_tdata, exp);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge i_sclk);
    #1;
  endtask

  function automatic logic [1:0] code_of(input int d, input int t);
    if (d >= t) return 2'b01;
`ifdef BACT_TERNARY_EN
    if (d <= -t) return 2'b11;
`endif
    return 2'b00;
  endfunction

  task automatic m_add(input logic [1:0] c);
    m_word[m_cnt*2 +: 2] = c;
    m_cnt++;
    if (m_cnt == PK) begin
      sb.push_back(m_word);
      m_word = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic m_flush();
    if (m_cnt != 0) begin
      sb.push_back(m_word);
      m_word = '0;
      m_cnt  = 0;
      m_err  = 1'b1;
    end
  endtask

  task automatic beat(input int d);
    m_add(code_of(d, m_thr[m_ch]));
    i_valid = 1'b1;
    i_tdata = WI'(d);
    step();
    i_valid = 1'b0;
  endtask

  task automatic reuse(input logic with_beat, input int d);
    m_flush();
    if (with_beat) m_add(code_of(d, m_thr[m_ch]));
    if (m_ch < CH - 1) m_ch++;
    i_reuse = 1'b1;
    i_valid = with_beat;
    i_tdata = WI'(d);
    step();
    i_reuse = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic hsync();
    m_flush();
    m_ch = 0;
    i_hsync = 1'b1;
    step();
    i_hsync = 1'b0;
  endtask

  task automatic vsync_write(input logic with_write, input int v);
    if (with_write) m_thr[0] = v;
    m_wr  = 0;
    m_err = 1'b0;
    i_vsync   = 1'b1;
    i_thr_vld = with_write;
    i_thr     = WI'(v);
    step();
    i_vsync   = 1'b0;
    i_thr_vld = 1'b0;
  endtask

  task automatic thr_write(input int v);
    m_thr[m_wr] = v;
    m_wr = (m_wr + 1) % CH;
    i_thr_vld = 1'b1;
    i_thr     = WI'(v);
    step();
    i_thr_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    repeat (4) step();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, sb.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({o_vsync, o_hsync, o_reuse, o_valid} !== 4'b0)
      $display("FAIL reset_strobes: got %b expected 0000", {o_vsync, o_hsync, o_reuse, o_valid});
    else n_pass++;
    n_checks++;
    if (o_tdata !== 8'h00) $display("FAIL reset_tdata: got %b expected 0", o_tdata);
    else n_pass++;
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", o_err);
    else n_pass++;
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_binary();
    for (int i = 0; i < CH; i++) thr_write(100);
    hsync();
    beat(99); beat(100); beat(-5); beat(300);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (o_valid !== 1'b0) $display("FAIL lat_early%0d: o_valid=%b expected 0", i, o_valid);
      else n_pass++;
      step();
    end
    n_checks++;
    if (o_valid !== 1'b1) $display("FAIL lat_valid: o_valid=%b expected 1", o_valid);
    else n_pass++;
    n_checks++;
    if (o_tdata !== 8'b01_00_01_00) $display("FAIL binary_word: got %b expected 01000100", o_tdata);
    else n_pass++;
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL binary_err: got %b expected 0", o_err);
    else n_pass++;
    drain("binary");
  endtask

  task automatic test_ternary_pattern();
    logic [7:0] want;
`ifdef BACT_TERNARY_EN
    want = 8'b00_01_00_11;
`else
    want = 8'b00_01_00_00;
`endif
    beat(-100); beat(-99); beat(100); beat(0);
    step(); step();
    n_checks++;
    if (o_valid !== 1'b1 || o_tdata !== want)
      $display("FAIL pattern_word: valid=%b tdata=%b expected valid 1 tdata %b", o_valid, o_tdata, want);
    else n_pass++;
    drain("pattern");
  endtask

  task automatic test_flush();
    hsync();
    for (int i = 0; i < 6; i++) beat($urandom_range(600) - 300);
    reuse(1'b1, $urandom_range(600) - 300);
    for (int i = 0; i < 3; i++) beat($urandom_range(600) - 300);
    drain("flush");
    n_checks++;
    if (o_err !== m_err || m_err !== 1'b1) $display("FAIL flush_err: got %b expected 1", o_err);
    else n_pass++;
    vsync_write(1'b0, 0);
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL vsync_clr_err: got %b expected 0", o_err);
    else n_pass++;
  endtask

  task automatic test_thr_wrap();
    vsync_write(1'b0, 0);
    for (int i = 0; i < CH; i++) thr_write(10 * i + 20);
    thr_write(50);
    hsync();
    beat(49); beat(50); beat(10); beat(-300);
    drain("wrap65");
    vsync_write(1'b1, 7);
    hsync();
    beat(6); beat(7); beat(8); beat(-7);
    drain("vsync_write");
    reuse(1'b0, 0);
    beat(29); beat(30); beat(-30); beat(-29);
    drain("wrap_ch1");
    vsync_write(1'b0, 0);
    for (int i = 0; i < CH; i++) thr_write(100);
  endtask

  task automatic test_full_row();
    int start, lat;
    start = n_valid;
    m_flush(); m_ch = 0;
    i_hsync = 1'b1; step(); i_hsync = 1'b0; lat = 1;
    while (o_hsync !== 1'b1 && lat < 10) begin step(); lat++; end
    n_checks++;
    if (lat != 3) $display("FAIL hsync_lag: got %0d cycles expected 3", lat);
    else n_pass++;
    for (int c = 0; c < CH; c++) begin
      if (c == 1) begin
        m_flush(); m_ch++;
        i_reuse = 1'b1; step(); i_reuse = 1'b0; lat = 1;
        while (o_reuse !== 1'b1 && lat < 10) begin step(); lat++; end
        n_checks++;
        if (lat != 3) $display("FAIL reuse_lag: got %0d cycles expected 3", lat);
        else n_pass++;
      end else if (c > 1) begin
        reuse(1'b0, 0);
      end
      for (int b = 0; b < SZ; b++) beat($urandom_range(600) - 300);
    end
    drain("row");
    n_checks++;
    if (n_valid - start != CH * SZ / PK)
      $display("FAIL row_words: got %0d expected %0d", n_valid - start, CH * SZ / PK);
    else n_pass++;
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL row_err: got %b expected 0", o_err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    hsync();
    beat(150); beat(-150);
    i_rst = 1'b1;
    step();
    n_checks++;
    if ({o_vsync, o_hsync, o_reuse, o_valid, o_err} !== 5'b0 || o_tdata !== 8'h00)
      $display("FAIL midrst_outputs: strobes/err=%b tdata=%b expected all 0",
               {o_vsync, o_hsync, o_reuse, o_valid, o_err}, o_tdata);
    else n_pass++;
    step();
    i_rst = 1'b0;
    m_cnt = 0; m_word = '0; m_ch = 0; m_wr = 0; m_err = 1'b0;
    repeat (6) step();
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL midrst_err: got %b expected 0", o_err);
    else n_pass++;
    hsync();
    beat(99); beat(100); beat(101); beat(-200);
    drain("retain");
  endtask

  initial begin
    test_reset();
    test_binary();
    test_ternary_pattern();
    test_flush();
    test_thr_wrap();
    test_full_row();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
